// File: rtl/shift_sequencer.sv
// Multi-pass controller that drives a 16-bit barrel shifter (0-7 bits per pass)
// so that logical shifts of 0-15 bits can be done through valid/ready handshakes.
module shift_sequencer #(
  parameter int WIDTH    = 16,
  parameter int AMT_W    = 4,
  parameter int MAX_STEP = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_lr,
  output logic [WIDTH-1:0] sh_data,
  output logic [2:0]       sh_lr,
  output logic [2:0]       sh_amt,
  input  logic [WIDTH-1:0] sh_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [AMT_W-1:0] MAX_STEP_A = AMT_W'(MAX_STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic [2:0]       step;

  // Per-pass amount is capped at what the shifter can do in one go.
  assign step = (rem_q > MAX_STEP_A) ? 3'(MAX_STEP) : rem_q[2:0];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  // NOTE: every output and next-state signal gets a default first so no
  // path through the case statement can infer a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sh_amt    = 3'd0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          acc_d   = in_data;
          rem_d   = in_amt;
          dir_d   = in_lr;
          state_d = (in_amt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sh_amt = step;
        acc_d  = sh_f;
        rem_d  = rem_q - AMT_W'(step);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outside SHIFT the amount is zero, so the shifter simply passes acc through.
  assign sh_data  = acc_q;
  assign sh_lr    = {2'b00, dir_q};
  assign out_data = acc_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Randomized + directed bench for shift_sequencer; a behavioural barrel shifter
// sits on the sh_* port and results are compared with plain shift arithmetic.
module tb_shift_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        in_lr;
  logic [15:0] sh_data;
  logic [2:0]  sh_lr;
  logic [2:0]  sh_amt;
  logic [15:0] sh_f;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  shift_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_lr    (in_lr),
    .sh_data  (sh_data),
    .sh_lr    (sh_lr),
    .sh_amt   (sh_amt),
    .sh_f     (sh_f),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // The shared barrel shifter: combinational sll/srl by 0-7.
  always_comb begin
    if (sh_lr[0]) sh_f = sh_data << sh_amt;
    else          sh_f = sh_data >> sh_amt;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] lshift(input logic [15:0] d, input int amt, input logic lr);
    return lr ? (d << amt) : (d >> amt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " in_ready"},  32'(in_ready),  32'd1);
    check({tag, " out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " busy"},      32'(busy),      32'd0);
    check({tag, " out_data"},  32'(out_data),  32'h0);
    check({tag, " sh_data"},   32'(sh_data),   32'h0);
    check({tag, " sh_amt"},    32'(sh_amt),    32'd0);
    check({tag, " sh_lr"},     32'(sh_lr),     32'd0);
  endtask

  // Issue one request from IDLE, follow every pass, hold the result for
  // 'hold' cycles of backpressure while poking the input side, then release.
  task automatic run_req(input logic [15:0] d, input int amt, input logic lr, input int hold);
    int          k;
    int          left;
    logic [15:0] exp;
    k   = (amt + 6) / 7;
    exp = lshift(d, amt, lr);
    check("accept in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = 4'(amt);
    in_lr    = lr;
    tick();
    for (int i = 0; i < k; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      in_amt   = 4'($urandom);
      in_lr    = 1'($urandom);
      left = amt - 7 * i;
      check("shift busy",      32'(busy),      32'd1);
      check("shift in_ready",  32'(in_ready),  32'd0);
      check("shift out_valid", 32'(out_valid), 32'd0);
      check("shift sh_amt",    32'(sh_amt),    32'((left > 7) ? 7 : left));
      check("shift sh_lr",     32'(sh_lr),     32'({2'b00, lr}));
      check("shift sh_data",   32'(sh_data),   32'(lshift(d, 7 * i, lr)));
      tick();
    end
    check("done out_valid", 32'(out_valid), 32'd1);
    check("done out_data",  32'(out_data),  32'(exp));
    check("done sh_amt",    32'(sh_amt),    32'd0);
    check("done in_ready",  32'(in_ready),  32'd0);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      in_amt   = 4'($urandom);
      in_lr    = 1'($urandom);
      tick();
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold out_data",  32'(out_data),  32'(exp));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release busy",      32'(busy),      32'd0);
    check("release in_ready",  32'(in_ready),  32'd1);
    check("release out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_lr     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // out_ready in IDLE must be ignored
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle out_ready busy", 32'(busy), 32'd0);

    run_req(16'hA5A5, 0,  1'b1, 0);
    run_req(16'h0001, 5,  1'b1, 1);
    run_req(16'h8000, 15, 1'b0, 0);
    run_req(16'hFFFF, 9,  1'b1, 0);
    run_req(16'h1234, 7,  1'b0, 5);
    run_req(16'hC003, 14, 1'b1, 2);

    // Reset in the second SHIFT cycle of an amt=14 request.
    in_valid = 1'b1;
    in_data  = 16'hBEEF;
    in_amt   = 4'd14;
    in_lr    = 1'b0;
    tick();
    in_valid = 1'b0;
    check("midrst first pass sh_amt", 32'(sh_amt), 32'd7);
    tick();
    check("midrst second pass busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst no out_valid", 32'(out_valid), 32'd0);
    end
    run_req(16'h0010, 3, 1'b0, 0);

    for (int n = 0; n < 40; n++) begin
      run_req(16'($urandom), int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle controller that sequences the 16-bit barrelShifter datapath (sll/srl, 0–7 per pass) so that logical shifts of 0–15 bits are possible.
- Accepts one shift request over a valid/ready handshake and drives the shifter's data/direction/amount inputs.
- Feeds the shifter output back over as many passes as needed, then presents the result over a valid/ready output handshake.
- Sits between the ALU decode stage and the shared barrelShifter instance.

Parameters:
- WIDTH, 16, datapath width; must match the shifter.
- AMT_W, 4, request shift-amount width (0–15).
- MAX_STEP, 7, largest shift per pass; equals the shifter's 3-bit amount limit.

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  request valid
- in_ready  output  1  block can accept a request
- in_data  input  WIDTH  operand to shift
- in_amt  input  AMT_W  total shift amount
- in_lr  input  1  direction: 0 = srl (right, zero-fill MSB), 1 = sll (left, zero-fill LSB)
- sh_data  output  WIDTH  operand to shifter data input
- sh_lr  output  3  shifter direction select: 3'b000 = right, 3'b001 = left
- sh_amt  output  3  shifter amount for the current pass
- sh_f  input  WIDTH  shifter result (combinational from sh_*)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  WIDTH  shifted result
- busy  output  1  high in any state other than IDLE

Behaviour:
- **Registers:**
  - state ∈ {IDLE, SHIFT, DONE}
  - acc[WIDTH-1:0]
  - rem[AMT_W-1:0]
  - dir
- **Reset** (rst high at a rising edge, any state, including mid-shift):
  - state = IDLE, acc = 0, rem = 0, dir = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_data = 0, busy = 0, sh_data = 0, sh_amt = 0, sh_lr = 0.
  - An in-flight request is discarded; no result is produced for it.
- **IDLE:**
  - in_ready = 1.
  - On an edge with in_valid = 1: acc ← in_data, rem ← in_amt, dir ← in_lr.
  - If in_amt = 0, go to DONE; otherwise go to SHIFT.
- **SHIFT:**
  - in_ready = 0.
  - step = MAX_STEP if rem > MAX_STEP, else rem[2:0].
  - Outputs: sh_data = acc, sh_amt = step, sh_lr = {2'b00, dir}.
  - Each edge: acc ← sh_f, rem ← rem − step.
  - If rem − step = 0, go to DONE; otherwise stay in SHIFT.
- **Outside SHIFT:** sh_data = acc, sh_amt = 0, sh_lr = {2'b00, dir}, so the shifter passes acc through.
- **DONE:**
  - out_valid = 1, out_data = acc; in_ready = 0.
  - Hold until an edge with out_ready = 1, then go to IDLE.
  - out_data is stable while out_valid = 1 and out_ready = 0.
- **out_data outside DONE:** holds acc; don't-care for consumers.
- **Latency:**
  - Accept edge = edge 0. Number of passes k = ceil(in_amt / 7): 0 for amt 0, 1 for 1–7, 2 for 8–14, 3 for 15.
  - SHIFT occupies cycles 1..k; out_valid is first high in cycle k+1.
  - Minimum request-to-request spacing is k+2 cycles (one IDLE cycle is mandatory between requests).
- **Arithmetic:** rem subtraction never underflows because step ≤ rem. The result equals a logical shift of in_data by in_amt; an amount of 15 leaves only a single data bit.
- **Handshake / input-side boundaries:**
  - in_valid while in_ready = 0: ignored, no state change. The requester must hold the request until in_ready.
  - out_ready while not in DONE: ignored.
  - in_data, in_amt and in_lr are sampled only on the accept edge; later changes have no effect.

Test Plan:
- **Reset:** rst held 2 cycles → in_ready = 1, out_valid = 0, busy = 0, out_data = 16'h0000.
- **Zero shift:** in_data = 16'hA5A5, amt = 0, lr = 1 → out_valid in cycle 1, out_data = 16'hA5A5; no SHIFT cycle, sh_amt stays 0.
- **Single-pass left:** in_data = 16'h0001, amt = 5, lr = 1 → one SHIFT cycle with sh_amt = 5, sh_lr = 3'b001; out_data = 16'h0020 in cycle 2.
- **Multi-pass right:** in_data = 16'h8000, amt = 15, lr = 0 → sh_amt sequence 7, 7, 1; out_data = 16'h0001 in cycle 4.
  - Also in_data = 16'hFFFF, amt = 9, lr = 1 → sh_amt 7, 2; out_data = 16'hFE00.
- **Backpressure and ignored input:**
  - Hold out_ready = 0 for 5 cycles in DONE → out_valid and out_data stable.
  - Pulse in_valid with new data during SHIFT/DONE → ignored.
  - Release out_ready → IDLE next edge.
- **Reset mid-operation:** assert rst in the second SHIFT cycle of an amt = 14 request → next cycle IDLE, all outputs at reset values, no out_valid. A following request with amt = 3, data 16'h0010, lr = 0 → out_data = 16'h0002.
